// File: rtl/pkt_sched_if.sv
// rtl/pkt_sched_if.sv - channel, formatter and status signals of the packet scheduler
interface pkt_sched_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int PRIO_WIDTH    = 2,
  parameter int PAC_LEN_WIDTH = 3
);
  logic                     slv0_req_i, slv1_req_i, slv2_req_i;
  logic                     slv0_val_i, slv1_val_i, slv2_val_i;
  logic [DATA_WIDTH-1:0]    slv0_data_i, slv1_data_i, slv2_data_i;
  logic [PRIO_WIDTH-1:0]    slv0_prio_i, slv1_prio_i, slv2_prio_i;
  logic [PAC_LEN_WIDTH-1:0] slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i;
  logic                     a2s0_ack_o, a2s1_ack_o, a2s2_ack_o;
  logic                     f2a_id_req_i;
  logic                     f2a_ack_i;
  logic                     a2f_val_o;
  logic [1:0]               a2f_id_o;
  logic [DATA_WIDTH-1:0]    a2f_data_o;
  logic [PAC_LEN_WIDTH-1:0] a2f_pkglen_sel_o;
  logic                     busy_o;

  modport master (
    output slv0_req_i, slv1_req_i, slv2_req_i,
    output slv0_val_i, slv1_val_i, slv2_val_i,
    output slv0_data_i, slv1_data_i, slv2_data_i,
    output slv0_prio_i, slv1_prio_i, slv2_prio_i,
    output slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i,
    output f2a_id_req_i, f2a_ack_i,
    input  a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
    input  a2f_val_o, a2f_id_o, a2f_data_o, a2f_pkglen_sel_o, busy_o
  );

  modport slave (
    input  slv0_req_i, slv1_req_i, slv2_req_i,
    input  slv0_val_i, slv1_val_i, slv2_val_i,
    input  slv0_data_i, slv1_data_i, slv2_data_i,
    input  slv0_prio_i, slv1_prio_i, slv2_prio_i,
    input  slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i,
    input  f2a_id_req_i, f2a_ack_i,
    output a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
    output a2f_val_o, a2f_id_o, a2f_data_o, a2f_pkglen_sel_o, busy_o
  );
endinterface

// File: rtl/pkt_sched.sv
// rtl/pkt_sched.sv - strict-priority / round-robin packet scheduler feeding the formatter
module pkt_sched #(
  parameter int DATA_WIDTH    = 32,
  parameter int PRIO_WIDTH    = 2,
  parameter int PAC_LEN_WIDTH = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  pkt_sched_if.slave bus
);
  typedef enum logic {IDLE, XFER} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               id_q, last_id_q;
  logic [PAC_LEN_WIDTH-1:0] sel_q;
  logic [5:0]               cnt_q;

  logic [2:0]               req;
  logic [PRIO_WIDTH-1:0]    prio [3];
  logic [PAC_LEN_WIDTH-1:0] pkglen [3];
  logic [PRIO_WIDTH-1:0]    best_prio;
  logic                     any_req;
  logic [1:0]               rr_start;
  logic [2:0]               rr_idx;
  logic                     found;
  logic [1:0]               win_id;

  logic                     grant, beat, last_beat;
  logic                     val_mux;
  logic [DATA_WIDTH-1:0]    data_mux;

  function automatic logic [5:0] len_decode(input logic [PAC_LEN_WIDTH-1:0] sel);
    logic [5:0] len;
    case (sel)
      PAC_LEN_WIDTH'(0): len = 6'd4;
      PAC_LEN_WIDTH'(1): len = 6'd8;
      PAC_LEN_WIDTH'(2): len = 6'd16;
      default:           len = 6'd32;
    endcase
    return len;
  endfunction

  assign req       = {bus.slv2_req_i, bus.slv1_req_i, bus.slv0_req_i};
  assign prio[0]   = bus.slv0_prio_i;
  assign prio[1]   = bus.slv1_prio_i;
  assign prio[2]   = bus.slv2_prio_i;
  assign pkglen[0] = bus.slv0_pkglen_i;
  assign pkglen[1] = bus.slv1_pkglen_i;
  assign pkglen[2] = bus.slv2_pkglen_i;

  // Find the best priority first, then walk channels from the one after the
  // last winner so equal-priority requesters take turns.
  always_comb begin
    best_prio = '1;
    any_req   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (req[i] && (!any_req || prio[i] < best_prio)) begin
        best_prio = prio[i];
        any_req   = 1'b1;
      end
    end
    rr_start = (last_id_q == 2'd2) ? 2'd0 : last_id_q + 2'd1;
    win_id   = 2'd0;
    found    = 1'b0;
    rr_idx   = 3'd0;
    for (int k = 0; k < 3; k++) begin
      rr_idx = {1'b0, rr_start} + 3'(k);
      if (rr_idx >= 3'd3) rr_idx = rr_idx - 3'd3;
      if (!found && req[rr_idx[1:0]] && prio[rr_idx[1:0]] == best_prio) begin
        win_id = rr_idx[1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    val_mux  = 1'b0;
    data_mux = '0;
    case (id_q)
      2'd0:    begin val_mux = bus.slv0_val_i; data_mux = bus.slv0_data_i; end
      2'd1:    begin val_mux = bus.slv1_val_i; data_mux = bus.slv1_data_i; end
      2'd2:    begin val_mux = bus.slv2_val_i; data_mux = bus.slv2_data_i; end
      default: begin val_mux = 1'b0;           data_mux = '0;              end
    endcase
  end

  always_comb begin
    state_d              = state_q;
    grant                = 1'b0;
    beat                 = 1'b0;
    last_beat            = 1'b0;
    bus.busy_o           = 1'b0;
    bus.a2f_val_o        = 1'b0;
    bus.a2f_data_o       = '0;
    bus.a2s0_ack_o       = 1'b0;
    bus.a2s1_ack_o       = 1'b0;
    bus.a2s2_ack_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.f2a_id_req_i && any_req) begin
          grant   = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        bus.busy_o     = 1'b1;
        bus.a2f_val_o  = val_mux;
        bus.a2f_data_o = data_mux;
        beat           = val_mux & bus.f2a_ack_i;
        bus.a2s0_ack_o = beat && (id_q == 2'd0);
        bus.a2s1_ack_o = beat && (id_q == 2'd1);
        bus.a2s2_ack_o = beat && (id_q == 2'd2);
        last_beat      = beat && (cnt_q == 6'd1);
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      id_q      <= 2'd0;
      sel_q     <= '0;
      cnt_q     <= 6'd0;
      last_id_q <= 2'd2;
    end else begin
      state_q <= state_d;
      if (grant) begin
        id_q  <= win_id;
        sel_q <= pkglen[win_id];
        cnt_q <= len_decode(pkglen[win_id]);
      end else if (last_beat) begin
        cnt_q     <= 6'd0;
        last_id_q <= id_q;
      end else if (beat) begin
        cnt_q <= cnt_q - 6'd1;
      end
    end
  end

  // Id and length select are held after the packet, up to the next grant.
  assign bus.a2f_id_o         = id_q;
  assign bus.a2f_pkglen_sel_o = sel_q;
endmodule

// File: tb/tb_pkt_sched.sv
// tb/tb_pkt_sched.sv - randomized and directed checks of pkt_sched against a packet-level model
module tb_pkt_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_sched_if #(.DATA_WIDTH(32), .PRIO_WIDTH(2), .PAC_LEN_WIDTH(3)) bus ();
  pkt_sched #(.DATA_WIDTH(32), .PRIO_WIDTH(2), .PAC_LEN_WIDTH(3)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  logic        req [3];
  logic        val [3];
  logic [31:0] data [3];
  logic [1:0]  prio [3];
  logic [2:0]  pkglen [3];
  logic        id_req = 1'b0;
  logic        f_ack = 1'b0;

  assign bus.slv0_req_i = req[0];    assign bus.slv1_req_i = req[1];    assign bus.slv2_req_i = req[2];
  assign bus.slv0_val_i = val[0];    assign bus.slv1_val_i = val[1];    assign bus.slv2_val_i = val[2];
  assign bus.slv0_data_i = data[0];  assign bus.slv1_data_i = data[1];  assign bus.slv2_data_i = data[2];
  assign bus.slv0_prio_i = prio[0];  assign bus.slv1_prio_i = prio[1];  assign bus.slv2_prio_i = prio[2];
  assign bus.slv0_pkglen_i = pkglen[0]; assign bus.slv1_pkglen_i = pkglen[1]; assign bus.slv2_pkglen_i = pkglen[2];
  assign bus.f2a_id_req_i = id_req;
  assign bus.f2a_ack_i = f_ack;

  int errs = 0;
  int checks = 0;

  // Packet-level reference: who owns the formatter and how many beats remain.
  bit m_busy = 1'b0;
  int m_id = 0;
  int m_sel = 0;
  int m_last = 2;
  int m_rem = 0;

  logic [2:0] obs_ack;
  logic       obs_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int plen(input int sel);
    return (sel >= 3) ? 32 : (4 << sel);
  endfunction

  // Lower score wins: priority dominates, then distance from the last winner.
  function automatic int pick();
    int best_c = -1;
    int best_s = 1000;
    for (int c = 0; c < 3; c++) begin
      if (req[c]) begin
        int s = int'(prio[c]) * 4 + ((c - m_last - 1 + 6) % 3);
        if (s < best_s) begin best_s = s; best_c = c; end
      end
    end
    return best_c;
  endfunction

  task automatic step();
    logic [2:0]  e_ack;
    logic        e_val;
    logic [31:0] e_data;
    int          w;
    @(negedge clk);
    e_val  = m_busy && val[m_id];
    e_data = m_busy ? data[m_id] : 32'd0;
    e_ack  = 3'b000;
    if (e_val && f_ack) e_ack[m_id] = 1'b1;
    obs_ack  = {bus.a2s2_ack_o, bus.a2s1_ack_o, bus.a2s0_ack_o};
    obs_busy = bus.busy_o;
    check("busy", obs_busy, m_busy);
    check("id", bus.a2f_id_o, m_id);
    check("sel", bus.a2f_pkglen_sel_o, m_sel);
    check("val", bus.a2f_val_o, e_val);
    check("data", bus.a2f_data_o, e_data);
    check("ack", obs_ack, e_ack);
    if (rst) begin
      m_busy = 1'b0; m_id = 0; m_sel = 0; m_last = 2; m_rem = 0;
    end else if (!m_busy) begin
      w = pick();
      if (id_req && w >= 0) begin
        m_busy = 1'b1; m_id = w; m_sel = int'(pkglen[w]); m_rem = plen(m_sel);
      end
    end else if (e_ack != 3'b000) begin
      m_rem--;
      if (m_rem == 0) begin m_busy = 1'b0; m_last = m_id; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_all(input logic r, input logic [1:0] p, input logic [2:0] s);
    for (int c = 0; c < 3; c++) begin
      req[c] = r; val[c] = 1'b1; prio[c] = p; pkglen[c] = s; data[c] = $urandom;
    end
  endtask

  // mode 0 plain, 1 toggling valid, 2 mid-packet control changes, 3 reset after two beats
  task automatic run_packet(input int mode, input int exp_id, input int exp_beats, input string tag);
    int n_ack, n_other, cyc;
    bit changed;
    id_req = 1'b1;
    step();
    id_req = 1'b0;
    check({tag, "_gid"}, bus.a2f_id_o, exp_id);
    n_ack = 0; n_other = 0; cyc = 0; changed = 1'b0;
    while (cyc < 300) begin
      for (int c = 0; c < 3; c++) data[c] = $urandom;
      if (mode == 1) val[exp_id] = (cyc % 2 == 1);
      if (mode == 2 && n_ack == 3 && !changed) begin
        prio[0] = 2'd3; req[0] = 1'b0; req[1] = 1'b1; prio[1] = 2'd0; changed = 1'b1;
      end
      if (mode == 3 && n_ack == 2) begin rst = 1'b1; f_ack = 1'b0; end
      step();
      rst = 1'b0;
      f_ack = 1'b1;
      if (!obs_busy) break;
      for (int c = 0; c < 3; c++) begin
        if (c == exp_id) n_ack += int'(obs_ack[c]);
        else n_other += int'(obs_ack[c]);
      end
      cyc++;
    end
    check({tag, "_timeout"}, cyc < 300, 1'b1);
    check({tag, "_beats"}, n_ack, exp_beats);
    check({tag, "_other_acks"}, n_other, 0);
    if (mode == 1) check({tag, "_busy_cycles"}, cyc, 64);
    if (mode == 3) begin
      check({tag, "_post_rst_id"}, bus.a2f_id_o, 0);
      check({tag, "_post_rst_busy"}, bus.busy_o, 1'b0);
    end
  endtask

  initial begin
    set_all(1'b0, 2'd0, 3'd0);
    @(posedge clk);
    #1;
    do_reset();
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_id", bus.a2f_id_o, 0);
    check("rst_sel", bus.a2f_pkglen_sel_o, 0);
    f_ack = 1'b1;

    set_all(1'b1, 2'd0, 3'd0);
    prio[0] = 2'd1; prio[1] = 2'd0; prio[2] = 2'd2;
    run_packet(0, 1, 4, "prio_win");

    do_reset();
    set_all(1'b1, 2'd0, 3'd0);
    for (int i = 0; i < 6; i++) run_packet(0, i % 3, 4, "rr_order");

    do_reset();
    set_all(1'b0, 2'd0, 3'd0);
    req[2] = 1'b1; pkglen[2] = 3'd3;
    run_packet(1, 2, 32, "toggle_val");

    do_reset();
    set_all(1'b0, 2'd1, 3'd1);
    req[0] = 1'b1;
    run_packet(2, 0, 8, "mid_change");
    run_packet(0, 1, 8, "after_change");

    do_reset();
    set_all(1'b0, 2'd0, 3'd5);
    req[0] = 1'b1;
    run_packet(0, 0, 32, "sel5");
    req[0] = 1'b0;
    id_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("noreq_busy", obs_busy, 1'b0);
      check("noreq_ack", obs_ack, 3'b000);
    end
    id_req = 1'b0;

    set_all(1'b0, 2'd0, 3'd1);
    req[1] = 1'b1;
    run_packet(3, 1, 2, "mid_reset");
    set_all(1'b1, 2'd0, 3'd0);
    run_packet(0, 0, 4, "post_reset_tie");

    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 3; c++) begin
        req[c]  = ($urandom_range(0, 1) == 1);
        val[c]  = ($urandom_range(0, 3) != 0);
        data[c] = $urandom;
        if ($urandom_range(0, 7) == 0) begin
          prio[c]   = 2'($urandom_range(0, 3));
          pkglen[c] = 3'($urandom_range(0, 7));
        end
      end
      f_ack  = ($urandom_range(0, 3) != 0);
      id_req = ($urandom_range(0, 1) == 1);
      rst    = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
